// File: rtl/iro_meter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// iro_stage
// One inverting ring stage. While the ring is enabled the stage drives the
// inverse of its selected input; while disabled it presents its seed bit so
// the ring starts from a known pattern. The continuous-assignment delay models
// gate delay in simulation; synthesis ignores it. Hierarchy is kept so every
// stage stays a distinct cell in the netlist and the loop is not optimised.
//
// Ports:
//   in_sig    in   selected stage input (previous stage, mirror tap or hold)
//   seed_bit  in   value driven while ring_en=0
//   ring_en   in   1: invert in_sig, 0: drive seed_bit
//   out_sig   out  stage output
// -----------------------------------------------------------------------------
(* keep_hierarchy = "yes" *)
module iro_stage #(
    parameter int STAGE_DELAY = 1
) (
    input  logic in_sig,
    input  logic seed_bit,
    input  logic ring_en,
    output logic out_sig
);

    assign #(STAGE_DELAY) out_sig = ring_en ? ~in_sig : seed_bit;

endmodule

// -----------------------------------------------------------------------------
// iro_meter
// Instrumented ring oscillator with an on-chip frequency meter. The ring is
// free-running combinational logic; a clk-domain FSM seeds it, lets it run for
// gate_cycles clocks, freezes it, waits for the edge counter to settle and
// publishes the count of rising edges seen on stage 0.
//
// Parameters: N_STAGES (odd, >= N_MIN), N_MIN (odd, >= 5), SEL_W, GATE_W,
//             COUNT_W, PHASE_W (<= N_STAGES), STAGE_DELAY (ns, sim only).
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse, begins a measurement (dropped if busy)
//   seed         in   per-stage value while the ring is disabled (sampled at start)
//   len_sel      in   ring length select, L = min(N_MIN + 2*len_sel, N_STAGES)
//   gate_cycles  in   measurement window in clk cycles (sampled at start)
//   hold         in   forces stage 1 input to 0, stalling propagation
//   busy         out  high from the cycle after start until count_valid
//   count_valid  out  one-cycle pulse when count/overflow are updated
//   count        out  rising edges of stage 0 during the last window
//   overflow     out  edge counter wrapped during the last window
//   phases       out  raw stage outputs [PHASE_W-1:0], unregistered
// -----------------------------------------------------------------------------
module iro_meter #(
    parameter int N_STAGES    = 25,
    parameter int N_MIN       = 13,
    parameter int SEL_W       = 4,
    parameter int GATE_W      = 16,
    parameter int COUNT_W     = 24,
    parameter int PHASE_W     = 16,
    parameter int STAGE_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_STAGES-1:0] seed,
    input  logic [SEL_W-1:0]    len_sel,
    input  logic [GATE_W-1:0]   gate_cycles,
    input  logic                hold,
    output logic                busy,
    output logic                count_valid,
    output logic [COUNT_W-1:0]  count,
    output logic                overflow,
    output logic [PHASE_W-1:0]  phases
);

    localparam int IDX_W = $clog2(N_STAGES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    state_t              state_reg,       state_next;
    logic [N_STAGES-1:0] seed_reg,        seed_next;
    logic [IDX_W-1:0]    last_reg,        last_next;
    logic [GATE_W-1:0]   gate_reg,        gate_next;
    logic [GATE_W-1:0]   gate_ctr_reg,    gate_ctr_next;
    logic [1:0]          settle_ctr_reg,  settle_ctr_next;
    logic                busy_reg,        busy_next;
    logic                ring_en_reg,     ring_en_next;
    logic                clr_ro_reg,      clr_ro_next;
    logic                count_valid_reg, count_valid_next;
    logic [COUNT_W-1:0]  count_reg,       count_next;
    logic                overflow_reg,    overflow_next;

    logic [31:0]         len_calc;
    logic [IDX_W-1:0]    last_calc;

    // Ring signals
    logic [N_STAGES-1:0] stage_in;
    logic [N_STAGES-1:0] stage_out;
    logic                tap;

    // Edge counter (tap domain)
    logic [COUNT_W-1:0]  ro_cnt_reg;
    logic                ro_ovf_reg;
    logic                clr_ro;

    // ---------------------------------------------------------------------
    // Ring length: clamp to the physical ring, store the index of the last
    // active stage so stage 0 can be fed from it directly.
    // ---------------------------------------------------------------------
    always_comb begin
        len_calc = 32'(N_MIN) + (32'(len_sel) << 1);
        if (len_calc > 32'(N_STAGES)) begin
            len_calc = 32'(N_STAGES);
        end
    end

    assign last_calc = IDX_W'(len_calc - 32'd1);

    // ---------------------------------------------------------------------
    // Ring fabric. Stages 0..N_MIN-2 are the fixed path; extension stages
    // join the chain up to index L-1. Bypassed extension stages shadow a
    // mirrored fixed-path stage so they keep a defined, loaded input but are
    // not part of the loop. Stage 0 closes the loop from the last active stage.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_in[gi] = stage_out[last_reg];
        end else if (gi == 1) begin : g_hold
            // hold pins this input low; with ring_en=0 the seed wins anyway
            assign stage_in[gi] = hold ? 1'b0 : stage_out[0];
        end else if (gi < N_MIN - 1) begin : g_fixed
            assign stage_in[gi] = stage_out[gi-1];
        end else begin : g_ext
            localparam int MIRROR = (N_MIN - 2) - ((gi - (N_MIN - 1)) % (N_MIN - 1));
            assign stage_in[gi] = (IDX_W'(gi) <= last_reg) ? stage_out[gi-1]
                                                           : stage_out[MIRROR];
        end

        iro_stage #(
            .STAGE_DELAY (STAGE_DELAY)
        ) u_stage (
            .in_sig   (stage_in[gi]),
            .seed_bit (seed_reg[gi]),
            .ring_en  (ring_en_reg),
            .out_sig  (stage_out[gi])
        );
    end

    assign tap    = stage_out[0];
    assign phases = stage_out[PHASE_W-1:0];

    // ---------------------------------------------------------------------
    // Edge counter clocked by the ring itself. rst forces the clear so an
    // aborted measurement leaves no residue.
    // ---------------------------------------------------------------------
    assign clr_ro = rst | clr_ro_reg;

    always_ff @(posedge tap or posedge clr_ro) begin
        if (clr_ro) begin
            ro_cnt_reg <= '0;
            ro_ovf_reg <= 1'b0;
        end else begin
            ro_cnt_reg <= ro_cnt_reg + COUNT_W'(1);
            if (&ro_cnt_reg) begin
                ro_ovf_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Measurement FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            seed_reg        <= '0;
            last_reg        <= IDX_W'(N_MIN - 1);
            gate_reg        <= '0;
            gate_ctr_reg    <= '0;
            settle_ctr_reg  <= '0;
            busy_reg        <= 1'b0;
            ring_en_reg     <= 1'b0;
            clr_ro_reg      <= 1'b0;
            count_valid_reg <= 1'b0;
            count_reg       <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            seed_reg        <= seed_next;
            last_reg        <= last_next;
            gate_reg        <= gate_next;
            gate_ctr_reg    <= gate_ctr_next;
            settle_ctr_reg  <= settle_ctr_next;
            busy_reg        <= busy_next;
            ring_en_reg     <= ring_en_next;
            clr_ro_reg      <= clr_ro_next;
            count_valid_reg <= count_valid_next;
            count_reg       <= count_next;
            overflow_reg    <= overflow_next;
        end
    end

    // ---------------------------------------------------------------------
    // Measurement FSM: next state. The ring controls are registered decodes of
    // the next state so ring_en and clr_ro are glitch-free at the ring.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        seed_next        = seed_reg;
        last_next        = last_reg;
        gate_next        = gate_reg;
        gate_ctr_next    = gate_ctr_reg;
        settle_ctr_next  = settle_ctr_reg;
        count_valid_next = 1'b0;
        count_next       = count_reg;
        overflow_next    = overflow_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    seed_next  = seed;
                    last_next  = last_calc;
                    gate_next  = gate_cycles;
                end
            end
            ST_LOAD: begin
                // A zero window skips RUN entirely, so the cleared counter
                // is reported as-is.
                if (gate_reg == '0) begin
                    state_next      = ST_SETTLE;
                    settle_ctr_next = 2'd3;
                end else begin
                    state_next    = ST_RUN;
                    gate_ctr_next = gate_reg;
                end
            end
            ST_RUN: begin
                // Leaving when the counter reads 1 gives exactly gate_reg
                // cycles with the ring enabled.
                if (gate_ctr_reg == GATE_W'(1)) begin
                    state_next      = ST_SETTLE;
                    settle_ctr_next = 2'd3;
                end else begin
                    gate_ctr_next = gate_ctr_reg - GATE_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_ctr_reg == 2'd0) begin
                    // The ring has been frozen for several clocks, so the
                    // tap-domain counter is static when captured here.
                    state_next       = ST_DONE;
                    count_next       = ro_cnt_reg;
                    overflow_next    = ro_ovf_reg;
                    count_valid_next = 1'b1;
                end else begin
                    settle_ctr_next = settle_ctr_reg - 2'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_next    = (state_next != ST_IDLE);
    assign ring_en_next = (state_next == ST_RUN);
    assign clr_ro_next  = (state_next == ST_LOAD);

    assign busy        = busy_reg;
    assign count_valid = count_valid_reg;
    assign count       = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_iro_meter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_iro_meter
// Directed bench for iro_meter. Seeds are chosen so the ring holds exactly one
// travelling edge: an alternating pattern whose only inconsistency sits at the
// stage-0 input. With 1 ns per stage the period is 2*L ns, so a window of
// g cycles at 100 ns yields about g*100/(2*L) rising edges on stage 0.
// -----------------------------------------------------------------------------
module tb_iro_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic [24:0] seed = '0;
    logic [3:0]  len_sel = '0;
    logic [15:0] gate_cycles = '0;
    logic        hold = 1'b0;

    logic        busy, cv, ovf;
    logic [23:0] count;
    logic [15:0] phases;

    logic        busy8, cv8, ovf8;
    logic [7:0]  count8;
    logic [15:0] phases8;

    int checks   = 0;
    int failures = 0;

    always #50 clk = ~clk;

    iro_meter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .len_sel     (len_sel),
        .gate_cycles (gate_cycles),
        .hold        (hold),
        .busy        (busy),
        .count_valid (cv),
        .count       (count),
        .overflow    (ovf),
        .phases      (phases)
    );

    iro_meter #(
        .COUNT_W (8)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .seed        (seed),
        .len_sel     (len_sel),
        .gate_cycles (gate_cycles),
        .hold        (hold),
        .busy        (busy8),
        .count_valid (cv8),
        .count       (count8),
        .overflow    (ovf8),
        .phases      (phases8)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        checks++;
        diff = (obs > exp) ? (obs - exp) : (exp - obs);
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // One full measurement on either instance; start is driven on a negedge
    // so the following posedge (E0) samples it and the next negedge is cycle 1.
    task automatic run_meas(input string tag, input bit use8, input logic [24:0] sd,
                            input logic [3:0] ls, input logic [15:0] gc, input bit hld,
                            input longint exp_cnt, input longint tol, input bit exp_ovf,
                            input bit chk_phase);
        int     n;
        int     busy_lo;
        bit     seen;
        longint got_cnt;
        longint got_ovf;
        seed = sd; len_sel = ls; gate_cycles = gc; hold = hld;
        @(negedge clk);
        if (use8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        n = 1; busy_lo = 0; seen = 1'b0; got_cnt = -1; got_ovf = -1;
        while (!seen && n <= int'(gc) + 40) begin
            if (chk_phase && n == 1) chk({tag, "/load_phases"}, longint'(phases), longint'(sd[15:0]), 0);
            if (!(use8 ? busy8 : busy)) busy_lo++;
            if (use8 ? cv8 : cv) begin
                seen    = 1'b1;
                got_cnt = use8 ? longint'(count8) : longint'(count);
                got_ovf = use8 ? longint'(ovf8) : longint'(ovf);
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "/latency"}, seen ? longint'(n) : -1, longint'(gc) + 6, 0);
        chk({tag, "/count"}, got_cnt, exp_cnt, tol);
        chk({tag, "/overflow"}, got_ovf, longint'(exp_ovf), 0);
        chk({tag, "/busy_steady"}, longint'(busy_lo), 0, 0);
        $display("meas %s: count=%0d ovf=%0d latency=%0d", tag, got_cnt, got_ovf, n);
        @(negedge clk);
        hold = 1'b0;
        chk({tag, "/valid_pulse"}, longint'(use8 ? cv8 : cv), 0, 0);
        chk({tag, "/busy_after"}, longint'(use8 ? busy8 : busy), 0, 0);
        chk({tag, "/count_held"}, use8 ? longint'(count8) : longint'(count), got_cnt, 0);
        if (chk_phase) chk({tag, "/idle_phases"}, longint'(phases), longint'(sd[15:0]), 0);
    endtask

    initial begin
        int n_cv;

        // Reset with a non-zero seed on the input: seed_q must stay zero.
        seed = 25'h155_5555;
        #10 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset/count", longint'(count), 0, 0);
        chk("reset/busy", longint'(busy), 0, 0);
        chk("reset/valid", longint'(cv), 0, 0);
        chk("reset/overflow", longint'(ovf), 0, 0);
        chk("reset/phases", longint'(phases), 0, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle/phases", longint'(phases), 0, 0);
        chk("idle/busy", longint'(busy), 0, 0);
        $display("reset: count=%0d busy=%0d phases=%h", count, busy, phases);

        // L=25 (clamped), 100 cycles: 10 us / 50 ns
        run_meas("long", 1'b0, 25'h155_5555, 4'd15, 16'd100, 1'b0, 200, 1, 1'b0, 1'b0);
        // L=13, 100 cycles: 10 us / 26 ns = 384.6
        run_meas("short", 1'b0, 25'h155_5555, 4'd0, 16'd100, 1'b0, 384, 1, 1'b0, 1'b1);
        // hold for the whole window: at most the initial edge reaches stage 0
        run_meas("hold", 1'b0, 25'h155_5555, 4'd15, 16'd100, 1'b1, 0, 1, 1'b0, 1'b0);
        run_meas("unhold", 1'b0, 25'h0AA_AAAA, 4'd15, 16'd100, 1'b0, 200, 1, 1'b0, 1'b1);
        // zero window: straight to SETTLE, count_valid 6 cycles after start
        run_meas("gate0", 1'b0, 25'h155_5555, 4'd15, 16'd0, 1'b0, 0, 0, 1'b0, 1'b0);

        // start re-pulsed during RUN and during SETTLE must be dropped
        seed = 25'h155_5555; len_sel = 4'd15; gate_cycles = 16'd20; hold = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_cv = 0;
        for (int i = 1; i <= 60; i++) begin
            if (cv) n_cv++;
            start = (i == 5 || i == 24);
            @(negedge clk);
        end
        start = 1'b0;
        chk("repulse/valid_count", longint'(n_cv), 1, 0);
        chk("repulse/count", longint'(count), 40, 1);
        chk("repulse/busy", longint'(busy), 0, 0);
        $display("meas repulse: valid_pulses=%0d count=%0d", n_cv, count);

        // asynchronous reset in the middle of RUN
        seed = 25'h155_5555; len_sel = 4'd15; gate_cycles = 16'd100;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst/busy_before", longint'(busy), 1, 0);
        rst = 1'b1;
        #1;
        chk("midrst/busy", longint'(busy), 0, 0);
        chk("midrst/count", longint'(count), 0, 0);
        chk("midrst/valid", longint'(cv), 0, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst/phases", longint'(phases), 0, 0);
        $display("reset mid-run: busy=%0d count=%0d", busy, count);
        run_meas("after_rst", 1'b0, 25'h155_5555, 4'd15, 16'd100, 1'b0, 200, 1, 1'b0, 1'b0);

        // 8-bit counter build: 400 edges wrap to 144 with overflow
        run_meas("wrap8", 1'b1, 25'h155_5555, 4'd15, 16'd200, 1'b0, 144, 1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iro_meter.md
Name: iro_meter

Overview:
- Parametrised successor to the instrumented ring oscillator: a ring of N_STAGES inverting stages with a selectable odd active length, a per-stage seed state and a hold stage.
- Adds an on-chip frequency meter. A clk-domain FSM loads the seed, runs the ring for a programmable gate window, freezes it and reports the edge count.
- Sits between the tt_um wrapper I/O and the ring cells. The ring stays free-running combinational logic; only the control and readout are synchronous.

Parameters:
- N_STAGES, 25, total stages; must be odd and ≥ N_MIN.
- N_MIN, 13, shortest ring length; must be odd and ≥ 5.
- SEL_W, 4, width of len_sel.
- GATE_W, 16, width of gate_cycles.
- COUNT_W, 24, width of count.
- PHASE_W, 16, number of stage outputs exported; must be ≤ N_STAGES.
- STAGE_DELAY, 1, simulation-only per-stage delay in ns; ignored by synthesis.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a measurement; ignored while busy.
- seed  in  N_STAGES  per-stage output value while the ring is disabled; sampled at start.
- len_sel  in  SEL_W  ring length select; sampled at start.
- gate_cycles  in  GATE_W  measurement window in clk cycles; sampled at start.
- hold  in  1  forces stage 1 to select constant 0, stalling propagation.
- busy  out  1  high from the cycle after start until count_valid.
- count_valid  out  1  one-cycle pulse when count is updated.
- count  out  COUNT_W  rising edges of the measurement tap during the last window.
- overflow  out  1  sticky; set if the RO counter wrapped in the last window.
- phases  out  PHASE_W  stage outputs [PHASE_W-1:0], unregistered.

Behaviour:
- Reset values: busy=0, count_valid=0, count=0, overflow=0. Ring disabled, so each stage output equals its seed_q bit, and seed_q=0. FSM in IDLE.
- Ring length: L = min(N_MIN + 2*len_sel_q, N_STAGES). L is always odd.
  - Stages 0..N_MIN-2 form the fixed path.
  - Stage N_MIN-1+k takes its input from the tail when k < L-N_MIN+1.
  - Otherwise it bypasses, taking its input from the mirrored fixed-path stage, as in the existing loopback structure.
  - Stage 0 is fed by the last stage.
  - Every stage output is: seed_q bit when ring_en=0; else NOT(selected input).
- Measurement tap: output of stage 0.
- RO counter:
  - COUNT_W ripple/binary counter clocked on the tap rising edge.
  - Asynchronously cleared while clr_ro=1.
  - Carry-out sets ro_ovf.
- FSM states and transitions:
  - IDLE: on start, go to LOAD and capture seed, len_sel and gate_cycles. Set busy=1 from the next cycle.
  - LOAD (1 cycle): clr_ro=1, ring_en=0, so stages present seed_q. Then go to RUN and load gate_ctr = gate_cycles.
  - RUN: clr_ro=0, ring_en=1, and gate_ctr decrements each cycle. When gate_ctr==0, go to SETTLE with ring_en=0. The window therefore lasts exactly gate_cycles clk cycles. If gate_cycles=0, RUN lasts 0 cycles, passes straight to SETTLE and yields count=0.
  - SETTLE (4 cycles): ring frozen, so the counter is static before sampling. This is the only clock-domain crossing and needs no synchroniser.
  - DONE (1 cycle): count <= RO counter; overflow <= ro_ovf; count_valid=1; busy=0 next cycle. Return to IDLE.
- While hold=1 during RUN, the ring stalls and count stops increasing. hold has no effect when ring_en=0.
- A start pulse while busy is dropped, with no queuing.
- rst mid-measurement:
  - Immediate return to IDLE, ring disabled, outputs to reset values.
  - RO counter cleared asynchronously, because clr_ro is forced to 1 by rst.
- count holds its value until the next DONE.
- Counter wrap: count equals (edges mod 2^COUNT_W), and overflow=1 for that result.
- Synthesis: each stage is its own kept-hierarchy cell, and no clk logic is inside the loop. STAGE_DELAY is applied per stage in simulation only.

Test Plan:
- Reset, then IDLE: hold rst high with seed=25'h155_5555. Required: count=0, busy=0, phases=0. After release with no start, phases stays 0.
- Longest ring, gate 100: clk 100 ns, STAGE_DELAY=1 ns, len_sel=15 (clamped to L=25), gate_cycles=100. Ring period is 50 ns over a 10 µs window. Required: count_valid after 1+100+4+1 cycles, count=200±1, overflow=0.
- Shortest ring: len_sel=0 (L=13, period 26 ns), gate_cycles=100. Required: count=384±1. Also, during LOAD phases[15:0] equals seed_q[15:0].
- hold asserted for the entire RUN with L=25, gate_cycles=100. Required: count ≤ 1. Then run with hold=0 and a different seed. Required: count=200±1 and busy never glitches.
- Edge cases:
  - gate_cycles=0. Required: count=0 and count_valid exactly 6 cycles after start.
  - start re-pulsed while busy. Required: exactly one count_valid.
  - COUNT_W=8 build with gate_cycles=200 at L=25. Required: count=400 mod 256 = 144±1 and overflow=1.
- rst pulse mid-RUN. Required: busy=0 and count=0 immediately. The next start completes normally with count=200±1.
